// File: rtl/fsm_share_arbiter.sv
// -----------------------------------------------------------------------------
// fsm_share_arbiter
//
// Purpose:
//   Shares one external 2-bit Moore FSM among NREQ serial requesters. A winner
//   is picked round-robin (or fixed priority, see below). The shared FSM is
//   pulsed into reset. BURST serial bits from the owner are streamed into it.
//   The FSM's final state is then returned, tagged with the owner index.
//
// Request/grant handshake:
//   A requester raises req[i] (a level) and keeps it high until done arrives
//   with done_id == i. Arbitration happens only while the sequencer is idle.
//   gnt[i] is high from the grant edge until the result edge. While granted,
//   the owner's req_bit[i] is forwarded to fsm_in. This happens
//   combinationally, and only during the RUN phase. If the owner drops req
//   while in CLEAR or RUN, the burst is abandoned and no done is produced.
//   done is a single-cycle pulse. result is held until the next done.
//
// Build option:
//   FSM_ARB_FIXED_PRI_EN - when defined, the lowest set req index always wins
//                          and the round-robin pointer stays at 0. Timing is
//                          otherwise identical.
//
// Parameters:
//   NREQ  - number of requesters (>= 2, any value)
//   BURST - serial bits streamed per grant (>= 1)
//   IDW   - width of done_id, 2**IDW >= NREQ
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   req        in   [NREQ] request levels
//   req_bit    in   [NREQ] serial data bit per requester
//   gnt        out  [NREQ] registered one-hot grant
//   busy       out  high whenever the sequencer is not idle
//   fsm_in     out  input bit driven into the shared FSM
//   fsm_rst    out  registered active-high reset for the shared FSM
//   fsm_state  in   [2] current state of the shared FSM
//   done       out  one-cycle result-valid pulse
//   done_id    out  [IDW] owner index of the result
//   result     out  [2] captured FSM state
//   dbg_state  out  [2] sequencer state (IDLE=0, CLEAR=1, RUN=2, REPORT=3)
// -----------------------------------------------------------------------------
module fsm_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 8,
    parameter int IDW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_bit,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            fsm_in,
    output logic            fsm_rst,
    input  logic [1:0]      fsm_state,
    output logic            done,
    output logic [IDW-1:0]  done_id,
    output logic [1:0]      result,
    output logic [1:0]      dbg_state
);

    localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [CNTW-1:0] cnt;

    // Arbitration signals
    logic [IDW-1:0]  scan_base;
    logic [NREQ-1:0] req_rot;
    logic [IDW-1:0]  win_off;
    logic [IDW:0]    win_sum;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            req_any;

    // Owner-side signals
    logic            owner_req;
    logic            owner_bit;
    logic [IDW-1:0]  ptr_after_owner;

    // Index that follows v, wrapping at NREQ-1 -> 0. NREQ need not be a power
    // of two, so a plain increment cannot be used.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        logic [IDW:0] nxt;
        nxt = {1'b0, v} + 1'b1;
        if (nxt >= (IDW+1)'(NREQ)) begin
            return '0;
        end
        return nxt[IDW-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration. The request vector is rotated so that bit 0 is the
    // requester at scan_base. The lowest set bit of the rotated vector is
    // taken, and its offset is mapped back to an absolute index.
    // -------------------------------------------------------------------------
    always_comb begin
`ifdef FSM_ARB_FIXED_PRI_EN
        scan_base = '0;
`else
        scan_base = ptr;
`endif
        req_rot = NREQ'({req, req} >> scan_base);

        win_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = IDW'(k);
            end
        end

        win_sum = {1'b0, scan_base} + {1'b0, win_off};
        if (win_sum >= (IDW+1)'(NREQ)) begin
            win_sum = win_sum - (IDW+1)'(NREQ);
        end
        win_idx    = win_sum[IDW-1:0];
        win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        req_any    = |req;
    end

    // gnt is onehot(owner) for the whole time the owner matters. Masking
    // with it selects the owner's lines without a variable index.
    assign owner_req = |(req & gnt);
    assign owner_bit = |(req_bit & gnt);

`ifdef FSM_ARB_FIXED_PRI_EN
    assign ptr_after_owner = '0;
`else
    assign ptr_after_owner = wrap_inc(owner);
`endif

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            fsm_rst <= 1'b1;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            ptr     <= '0;
            cnt     <= '0;
            owner   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt     <= win_onehot;
                        owner   <= win_idx;
                        fsm_rst <= 1'b1;
                        state   <= CLEAR;
                    end else begin
                        fsm_rst <= 1'b0;
                    end
                end

                CLEAR: begin
                    if (!owner_req) begin
                        gnt     <= '0;
                        fsm_rst <= 1'b0;
                        ptr     <= ptr_after_owner;
                        state   <= IDLE;
                    end else begin
                        fsm_rst <= 1'b0;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    if (!owner_req) begin
                        gnt     <= '0;
                        fsm_rst <= 1'b0;
                        ptr     <= ptr_after_owner;
                        state   <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= REPORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                REPORT: begin
                    // The last RUN edge has already clocked the final bit
                    // into the FSM, so fsm_state is the complete answer here.
                    result  <= fsm_state;
                    done    <= 1'b1;
                    done_id <= owner;
                    gnt     <= '0;
                    ptr     <= ptr_after_owner;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_in    = (state == RUN) && owner_bit;
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    gnt_onehot0_a : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(gnt));

    busy_matches_gnt_a : assert property (@(posedge clk) disable iff (!reset)
        busy == (gnt != '0));

    done_only_idle_a : assert property (@(posedge clk) disable iff (!reset)
        done |-> !busy);

endmodule
